pipeline_stall_ctrl: RTL and testbench
======================================

Name: pipeline_stall_ctrl

Overview:
Central pipeline sequencer for the 5-stage core. It merges the load-use and control-hazard indications with data-memory wait states and the multi-cycle (iterative mul/div) execution unit, and produces one prioritised set of per-stage stall/flush/bubble controls. It also issues start/kill to the multi-cycle unit and keeps a saturating stall-cycle performance counter. It sits beside the hazard/forwarding logic and drives the PC and pipeline-register enables.

Parameters:
CNT_W, 32, width of stall performance counter (saturating)
MC_TIMEOUT, 64, cycles in MC_BUSY before mc_timeout_o sets (debug watchdog, no recovery action)

Ports:
clk  input  1  core clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
load_use_hazard_i  input  1  load in EX feeds rs1/rs2 of ID instruction
branch_flush_i  input  1  taken branch/jump resolved in MEM
ex_mc_op_i  input  1  valid mul/div instruction currently in EX
mc_done_i  input  1  multi-cycle unit result valid (1-cycle pulse)
dmem_req_i  input  1  MEM-stage instruction accessing data memory
dmem_ready_i  input  1  data memory completes access this cycle
pc_stall_o  output  1  hold PC
if_id_stall_o  output  1  hold IF/ID
if_id_flush_o  output  1  clear IF/ID to NOP
id_ex_stall_o  output  1  hold ID/EX
id_ex_flush_o  output  1  clear ID/EX to NOP
ex_mem_stall_o  output  1  hold EX/MEM
ex_mem_flush_o  output  1  insert bubble into EX/MEM
mem_wb_flush_o  output  1  insert bubble into MEM/WB
mc_start_o  output  1  start pulse to multi-cycle unit
mc_kill_o  output  1  abort multi-cycle unit (1-cycle pulse)
mc_timeout_o  output  1  sticky watchdog flag
state_o  output  2  FSM state (debug)
stall_cnt_o  output  CNT_W  cycles with pc_stall_o=1, saturating

Behaviour:
- Reset (async, rst_n=0): state=RUN, mc_timeout_o=0, stall_cnt_o=0, busy counter=0, done_pend=0; all stall/flush/start/kill outputs 0 while in reset.
- Outputs combinational from registered state plus inputs; state/counters update on clk rising edge.
- mem_wait = dmem_req_i & ~dmem_ready_i.
- States: RUN=0, MC_BUSY=1, MC_HOLD=2 (result done, waiting for MEM release).
- Priority each cycle (highest first): mem_wait > branch_flush_i > multi-cycle > load_use_hazard_i.
- mem_wait: pc, if_id, id_ex, ex_mem stall; mem_wb_flush_o=1; all other actions suppressed (no flush, no mc_start). FSM state is held, but the MC_BUSY busy counter still advances.
- branch_flush_i (no mem_wait): if_id_flush_o=id_ex_flush_o=ex_mem_flush_o=1, no stalls. If state is MC_BUSY or MC_HOLD, mc_kill_o=1 and next state=RUN (the younger mul/div is squashed). A branch coincident with ex_mc_op_i in RUN gives no mc_start_o.
- RUN & ex_mc_op_i: mc_start_o=1 for exactly one cycle; pc, if_id, id_ex stall; ex_mem_flush_o=1; next=MC_BUSY; busy counter cleared.
- MC_BUSY: pc, if_id, id_ex stall; ex_mem_flush_o=1; busy counter increments, saturating at MC_TIMEOUT. Reaching MC_TIMEOUT sets mc_timeout_o, which holds until reset. On mc_done_i with no mem_wait: all stalls drop in the same cycle so EX advances; next=RUN. On mc_done_i with mem_wait: next=MC_HOLD.
- MC_HOLD: stalls as in MC_BUSY while mem_wait persists. On the first cycle without mem_wait, release all stalls; next=RUN. mc_start_o is never re-asserted for the same instruction.
- load_use_hazard_i (RUN, nothing higher): pc and if_id stall; id_ex_flush_o=1.
- stall_cnt_o increments whenever pc_stall_o=1, saturating at 2^CNT_W-1.
- Reset mid-operation: immediately returns to RUN. No mc_kill_o is issued; the multi-cycle unit is reset by the same rst_n.

Test Plan:
- Reset, then idle inputs -> all controls 0, state_o=0, stall_cnt_o=0.
- load_use_hazard_i high for 1 cycle -> pc_stall_o=if_id_stall_o=id_ex_flush_o=1 that cycle; stall_cnt_o=1.
- ex_mc_op_i, mc_done_i 5 cycles later -> mc_start_o single pulse; stalls for 5 cycles plus release on the done cycle (stalls 0); state_o 0→1→0; stall_cnt_o=5.
- MC_BUSY with dmem_req_i=1, dmem_ready_i=0 across mc_done_i, ready returns 3 cycles later -> state_o=2; mem_wb_flush_o=1 during wait; release on the ready cycle; no second mc_start_o.
- MC_BUSY plus branch_flush_i -> mc_kill_o=1, if_id/id_ex/ex_mem flushes=1, state_o=0 next cycle; simultaneous load_use_hazard_i is ignored.
- Hold MC_BUSY for 70 cycles with MC_TIMEOUT=64 -> mc_timeout_o sets at cycle 64, stays 1 after mc_done_i until rst_n=0.

Source files
------------

// File: rtl/pipeline_stall_ctrl.sv
// Central pipeline sequencer: merges memory waits, branch flushes, multi-cycle
// execution and load-use hazards into one prioritised set of stage controls.
module pipeline_stall_ctrl #(
  parameter int CNT_W      = 32,
  parameter int MC_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_use_hazard_i,
  input  logic             branch_flush_i,
  input  logic             ex_mc_op_i,
  input  logic             mc_done_i,
  input  logic             dmem_req_i,
  input  logic             dmem_ready_i,
  output logic             pc_stall_o,
  output logic             if_id_stall_o,
  output logic             if_id_flush_o,
  output logic             id_ex_stall_o,
  output logic             id_ex_flush_o,
  output logic             ex_mem_stall_o,
  output logic             ex_mem_flush_o,
  output logic             mem_wb_flush_o,
  output logic             mc_start_o,
  output logic             mc_kill_o,
  output logic             mc_timeout_o,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  // state   | meaning
  // RUN     | normal flow, no multi-cycle op outstanding
  // MC_BUSY | multi-cycle unit running, EX held
  // MC_HOLD | multi-cycle result done, waiting for MEM to release
  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MC_BUSY = 2'd1,
    MC_HOLD = 2'd2
  } state_t;

  localparam int BW = $clog2(MC_TIMEOUT + 1);
  localparam logic [BW-1:0] BUSY_MAX = BW'(MC_TIMEOUT);

  state_t          state, state_nxt;
  logic [BW-1:0]   busy_cnt, busy_cnt_nxt;
  logic            mem_wait;

  assign mem_wait = dmem_req_i & ~dmem_ready_i;
  assign state_o  = state;

  always_comb begin
    state_nxt      = state;
    busy_cnt_nxt   = busy_cnt;
    pc_stall_o     = 1'b0;
    if_id_stall_o  = 1'b0;
    if_id_flush_o  = 1'b0;
    id_ex_stall_o  = 1'b0;
    id_ex_flush_o  = 1'b0;
    ex_mem_stall_o = 1'b0;
    ex_mem_flush_o = 1'b0;
    mem_wb_flush_o = 1'b0;
    mc_start_o     = 1'b0;
    mc_kill_o      = 1'b0;

    if (state == MC_BUSY && busy_cnt != BUSY_MAX)
      busy_cnt_nxt = busy_cnt + 1'b1;

    // Outputs are forced quiet while reset is held, whatever the inputs do.
    if (rst_n) begin
      if (mem_wait) begin
        pc_stall_o     = 1'b1;
        if_id_stall_o  = 1'b1;
        id_ex_stall_o  = 1'b1;
        ex_mem_stall_o = 1'b1;
        mem_wb_flush_o = 1'b1;
        if (state == MC_BUSY && mc_done_i)
          state_nxt = MC_HOLD;
      end else if (branch_flush_i) begin
        if_id_flush_o  = 1'b1;
        id_ex_flush_o  = 1'b1;
        ex_mem_flush_o = 1'b1;
        if (state != RUN) begin
          mc_kill_o = 1'b1;
          state_nxt = RUN;
        end
      end else begin
        case (state)
          RUN: begin
            if (ex_mc_op_i) begin
              mc_start_o     = 1'b1;
              pc_stall_o     = 1'b1;
              if_id_stall_o  = 1'b1;
              id_ex_stall_o  = 1'b1;
              ex_mem_flush_o = 1'b1;
              busy_cnt_nxt   = '0;
              state_nxt      = MC_BUSY;
            end else if (load_use_hazard_i) begin
              pc_stall_o    = 1'b1;
              if_id_stall_o = 1'b1;
              id_ex_flush_o = 1'b1;
            end
          end
          MC_BUSY: begin
            if (mc_done_i) begin
              state_nxt = RUN;
            end else begin
              pc_stall_o     = 1'b1;
              if_id_stall_o  = 1'b1;
              id_ex_stall_o  = 1'b1;
              ex_mem_flush_o = 1'b1;
            end
          end
          MC_HOLD: state_nxt = RUN;
          default: state_nxt = RUN;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= RUN;
      busy_cnt     <= '0;
      mc_timeout_o <= 1'b0;
      stall_cnt_o  <= '0;
    end else begin
      state    <= state_nxt;
      busy_cnt <= busy_cnt_nxt;
      if (state == MC_BUSY && busy_cnt_nxt == BUSY_MAX)
        mc_timeout_o <= 1'b1;
      if (pc_stall_o && !(&stall_cnt_o))
        stall_cnt_o <= stall_cnt_o + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Bench for pipeline_stall_ctrl: directed test-plan scenarios with literal
// checks plus randomized traffic, all compared every cycle to a priority model.
module tb_pipeline_stall_ctrl;
  localparam int CNT_W   = 6;
  localparam int TMO     = 64;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic lu = 0, br = 0, op = 0, dn = 0, req = 0, rdy = 0;
  logic pc_s, ifid_s, ifid_f, idex_s, idex_f, exmem_s, exmem_f, memwb_f, start, kill;
  logic tmo;
  logic [1:0] st;
  logic [CNT_W-1:0] scnt;

  int compared = 0;
  int mismatched = 0;

  // Model: phase 0 = idle, 1 = unit running, 2 = result waiting on memory.
  int m_ph = 0, m_busy = 0, m_scnt = 0;
  bit m_wd = 0;

  always #5 clk = ~clk;

  pipeline_stall_ctrl #(.CNT_W(CNT_W), .MC_TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .load_use_hazard_i(lu), .branch_flush_i(br), .ex_mc_op_i(op),
    .mc_done_i(dn), .dmem_req_i(req), .dmem_ready_i(rdy),
    .pc_stall_o(pc_s), .if_id_stall_o(ifid_s), .if_id_flush_o(ifid_f),
    .id_ex_stall_o(idex_s), .id_ex_flush_o(idex_f), .ex_mem_stall_o(exmem_s),
    .ex_mem_flush_o(exmem_f), .mem_wb_flush_o(memwb_f), .mc_start_o(start),
    .mc_kill_o(kill), .mc_timeout_o(tmo), .state_o(st), .stall_cnt_o(scnt)
  );

  // bit order: pc, ifid_s, ifid_f, idex_s, idex_f, exmem_s, exmem_f, memwb_f, start, kill
  function automatic logic [9:0] model_ctrl(int ph);
    logic [9:0] c;
    c = '0;
    if (!rst_n) return c;
    if (req && !rdy) begin
      c[9] = 1; c[8] = 1; c[6] = 1; c[4] = 1; c[2] = 1;
    end else if (br) begin
      c[7] = 1; c[5] = 1; c[3] = 1; c[0] = (ph != 0);
    end else if ((ph == 1 && !dn) || (ph == 0 && op)) begin
      c[9] = 1; c[8] = 1; c[6] = 1; c[3] = 1; c[1] = (ph == 0);
    end else if (ph == 0 && lu) begin
      c[9] = 1; c[8] = 1; c[5] = 1;
    end
    return c;
  endfunction

  function automatic logic [9:0] dut_ctrl();
    return {pc_s, ifid_s, ifid_f, idex_s, idex_f, exmem_s, exmem_f, memwb_f, start, kill};
  endfunction

  task automatic chk(string name, longint got, longint exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ph <= 0; m_busy <= 0; m_wd <= 0; m_scnt <= 0;
    end else begin
      logic [9:0] c;
      int nph, nbusy;
      c = model_ctrl(m_ph);
      nph = m_ph;
      nbusy = m_busy;
      if (c[9] && m_scnt < CNT_MAX) m_scnt <= m_scnt + 1;
      if (m_ph == 1) begin
        nbusy = (m_busy < TMO) ? m_busy + 1 : TMO;
        if (nbusy == TMO) m_wd <= 1;
      end
      if (req && !rdy) begin
        if (m_ph == 1 && dn) nph = 2;
      end else if (br) nph = 0;
      else if (m_ph == 0 && op) begin nph = 1; nbusy = 0; end
      else if (m_ph == 2 || (m_ph == 1 && dn)) nph = 0;
      m_ph <= nph;
      m_busy <= nbusy;
    end
  end

  always @(negedge clk) begin
    chk("ctrl", dut_ctrl(), model_ctrl(m_ph));
    chk("state", st, m_ph);
    chk("timeout", tmo, m_wd);
    chk("stall_cnt", scnt, m_scnt);
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    lu = 0; br = 0; op = 0; dn = 0; req = 0; rdy = 0;
  endtask

  initial begin
    idle();
    @(negedge clk);
    chk("rst_ctrl", dut_ctrl(), 0);
    chk("rst_state", st, 0);
    chk("rst_cnt", scnt, 0);
    tick(); rst_n = 1;
    tick(); tick();

    // load-use single cycle
    lu = 1; @(negedge clk);
    chk("lu_ctrl", dut_ctrl(), 10'b1100100000);
    tick(); lu = 0; @(negedge clk);
    chk("lu_cnt", scnt, 1);

    // multi-cycle op, done 5 cycles after start
    tick(); op = 1; @(negedge clk);
    chk("mc_start", start, 1);
    chk("mc_st0", st, 0);
    for (int i = 1; i < 5; i++) begin
      tick(); @(negedge clk);
      chk("mc_busy_st", st, 1);
      chk("mc_nostart", start, 0);
    end
    tick(); dn = 1; @(negedge clk);
    chk("mc_release", dut_ctrl(), 0);
    tick(); idle(); @(negedge clk);
    chk("mc_back_run", st, 0);
    chk("mc_cnt", scnt, 6);

    // memory wait across done
    tick(); op = 1;
    tick(); tick(); req = 1; rdy = 0; dn = 1; @(negedge clk);
    chk("mw_flush", memwb_f, 1);
    tick(); dn = 0; @(negedge clk);
    chk("hold_state", st, 2);
    chk("hold_flush", memwb_f, 1);
    tick(); @(negedge clk);
    chk("hold_nostart", start, 0);
    tick(); rdy = 1; @(negedge clk);
    chk("hold_release", pc_s, 0);
    chk("hold_rel_start", start, 0);
    tick(); idle(); @(negedge clk);
    chk("hold_done_st", st, 0);

    // branch kills running op, load-use ignored
    tick(); op = 1;
    tick(); op = 0; tick(); br = 1; lu = 1; @(negedge clk);
    chk("br_ctrl", dut_ctrl(), 10'b0010101001);
    tick(); idle(); @(negedge clk);
    chk("br_state", st, 0);

    // watchdog
    tick(); op = 1;
    for (int i = 1; i <= 70; i++) begin
      tick();
      if (i == 10) begin @(negedge clk); chk("wd_early", tmo, 0); end
    end
    @(negedge clk); chk("wd_set", tmo, 1);
    tick(); dn = 1; tick(); idle(); @(negedge clk);
    chk("wd_sticky", tmo, 1);
    tick(); rst_n = 0; @(negedge clk);
    chk("wd_reset", tmo, 0);
    tick(); rst_n = 1;

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      tick();
      lu  = ($urandom % 4) == 0;
      br  = ($urandom % 8) == 0;
      op  = ($urandom % 5) == 0;
      dn  = ($urandom % 4) == 0;
      req = ($urandom % 3) == 0;
      rdy = ($urandom % 2) == 0;
      rst_n = ($urandom % 400) != 0;
    end
    tick(); idle(); rst_n = 1;
    tick(); @(negedge clk); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
